// File: rtl/secuenciador_dispensador_if.sv
// Bus between the ATM controller/bill mechanism and the dispenser sequencer.
// master drives requests and ACK; slave is the sequencer.
interface secuenciador_dispensador_if;
    logic        ENTREGAR_DINERO;
    logic [31:0] MONTO;
    logic        RECARGA;
    logic        BILLETE_ACK;
    logic        BILLETE_REQ;
    logic [1:0]  CASETE_SEL;
    logic        DISPENSANDO;
    logic        ENTREGA_COMPLETA;
    logic        MONTO_NO_DISPENSABLE;
    logic        ERROR_DISPENSADOR;
    logic [31:0] MONTO_ENTREGADO;

    modport master (
        output ENTREGAR_DINERO, MONTO, RECARGA, BILLETE_ACK,
        input  BILLETE_REQ, CASETE_SEL, DISPENSANDO, ENTREGA_COMPLETA,
        input  MONTO_NO_DISPENSABLE, ERROR_DISPENSADOR, MONTO_ENTREGADO
    );

    modport slave (
        input  ENTREGAR_DINERO, MONTO, RECARGA, BILLETE_ACK,
        output BILLETE_REQ, CASETE_SEL, DISPENSANDO, ENTREGA_COMPLETA,
        output MONTO_NO_DISPENSABLE, ERROR_DISPENSADOR, MONTO_ENTREGADO
    );
endinterface

// File: rtl/secuenciador_dispensador.sv
// Cash-dispenser sequencer: greedy split over three cassettes, REQ/ACK per bill.
// Optional macro DISPENSADOR_LIMITE_EN caps the bill count per transaction.
module secuenciador_dispensador #(
`ifdef DISPENSADOR_LIMITE_EN
    parameter int MAX_BILLETES = 8,
`endif
    parameter int DEN_0       = 50,
    parameter int DEN_1       = 20,
    parameter int DEN_2       = 5,
    parameter int INV_INICIAL = 10,
    parameter int TIMEOUT     = 16
) (
    input logic                       clk,
    input logic                       reset,
    secuenciador_dispensador_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CALCULO, REQ_ALTO, ESPERA_BAJO, FIN
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [31:0]      resto_q, resto_d;
    logic [31:0]      entregado_q, entregado_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       sel_q, sel_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [2:0][15:0] cnt_q, cnt_d;
    logic [2:0][15:0] inv_q, inv_d;
    logic             nod_q, nod_d;
    logic             err_q, err_d;
    logic [2:0]       primero, siguiente;
    logic             excede;

    function automatic logic [31:0] den(input logic [1:0] i);
        case (i)
            2'd0:    den = 32'(DEN_0);
            2'd1:    den = 32'(DEN_1);
            default: den = 32'(DEN_2);
        endcase
    endfunction

    // {found, index} of the lowest cassette >= desde with bills still pending
    function automatic logic [2:0] buscar(input logic [2:0][15:0] c,
                                          input logic [1:0] desde);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (i >= int'(desde) && c[i] != 16'd0) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign primero   = buscar(cnt_q, 2'd0);
    assign siguiente = buscar(cnt_q, sel_q);

`ifdef DISPENSADOR_LIMITE_EN
    logic [17:0] total_bill;
    assign total_bill = {2'b00, cnt_q[0]} + {2'b00, cnt_q[1]} + {2'b00, cnt_q[2]};
    assign excede     = total_bill > 18'(MAX_BILLETES);
`else
    assign excede = 1'b0;
`endif

    // State and datapath registers; reset restores full inventory
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= IDLE;
            resto_q     <= '0;
            entregado_q <= '0;
            idx_q       <= '0;
            sel_q       <= '0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            inv_q       <= {3{16'(INV_INICIAL)}};
            nod_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            resto_q     <= resto_d;
            entregado_q <= entregado_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            nod_q       <= nod_d;
            err_q       <= err_d;
        end
    end

    // Next-state: split calculation, per-bill handshake, timeout supervision
    always_comb begin
        estado_d    = estado_q;
        resto_d     = resto_q;
        entregado_d = entregado_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        nod_d       = 1'b0;
        err_d       = 1'b0;
        case (estado_q)
            IDLE: begin
                if (bus.RECARGA) inv_d = {3{16'(INV_INICIAL)}};
                if (bus.ENTREGAR_DINERO) begin
                    resto_d     = bus.MONTO;
                    cnt_d       = '0;
                    entregado_d = '0;
                    idx_d       = '0;
                    estado_d    = CALCULO;
                end
            end
            CALCULO: begin
                if (resto_q >= den(idx_q) && cnt_q[idx_q] < inv_q[idx_q]) begin
                    resto_d      = resto_q - den(idx_q);
                    cnt_d[idx_q] = cnt_q[idx_q] + 16'd1;
                end else if (idx_q != 2'd2) begin
                    idx_d = idx_q + 2'd1;
                end else if (resto_q != 32'd0 || excede) begin
                    nod_d    = 1'b1;
                    estado_d = IDLE;
                end else if (!primero[2]) begin
                    estado_d = FIN;
                end else begin
                    sel_d    = primero[1:0];
                    estado_d = REQ_ALTO;
                end
            end
            REQ_ALTO: begin
                if (bus.BILLETE_ACK) begin
                    cnt_d[sel_q] = cnt_q[sel_q] - 16'd1;
                    inv_d[sel_q] = inv_q[sel_q] - 16'd1;
                    entregado_d  = entregado_q + den(sel_q);
                    estado_d     = ESPERA_BAJO;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    estado_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ESPERA_BAJO: begin
                if (!bus.BILLETE_ACK) begin
                    if (siguiente[2]) begin
                        sel_d    = siguiente[1:0];
                        estado_d = REQ_ALTO;
                    end else begin
                        estado_d = FIN;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    estado_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
        if (estado_d != estado_q) tmo_d = '0;
    end

    assign bus.BILLETE_REQ          = (estado_q == REQ_ALTO);
    assign bus.CASETE_SEL           = sel_q;
    assign bus.DISPENSANDO          = (estado_q != IDLE);
    assign bus.ENTREGA_COMPLETA     = (estado_q == FIN);
    assign bus.MONTO_NO_DISPENSABLE = nod_q;
    assign bus.ERROR_DISPENSADOR    = err_q;
    assign bus.MONTO_ENTREGADO      = entregado_q;
endmodule

// File: tb/tb_secuenciador_dispensador.sv
// Directed bench for secuenciador_dispensador.
// Expected values are hand-computed for DEN 50/20/5, 10 bills, timeout 16.
module tb_secuenciador_dispensador;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    secuenciador_dispensador_if bus ();

    secuenciador_dispensador dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    int          n_req_hi, n_bill, n_fin, n_nod, n_err;
    logic [31:0] sel_code;
    logic        req_prev = 1'b0;
    bit          echo = 1'b0;
    logic        d1 = 1'b0, d2 = 1'b0;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor: REQ cycles, per-bill cassette code, pulses
    initial forever begin
        @(posedge clk);
        #2;
        if (bus.BILLETE_REQ) n_req_hi++;
        if (bus.BILLETE_REQ && !req_prev) begin
            if (n_bill < 16) sel_code = sel_code | (32'(bus.CASETE_SEL) << (2 * n_bill));
            n_bill++;
        end
        req_prev = bus.BILLETE_REQ;
        if (bus.ENTREGA_COMPLETA)     n_fin++;
        if (bus.MONTO_NO_DISPENSABLE) n_nod++;
        if (bus.ERROR_DISPENSADOR)    n_err++;
    end

    // Mechanism model: ACK follows REQ two cycles later when echo is on
    initial forever begin
        @(posedge clk);
        #1;
        if (echo) begin
            bus.BILLETE_ACK = d2;
            d2 = d1;
            d1 = bus.BILLETE_REQ;
        end else begin
            bus.BILLETE_ACK = 1'b0;
            d1 = 1'b0;
            d2 = 1'b0;
        end
    end

    task automatic clr();
        n_req_hi = 0;
        n_bill   = 0;
        n_fin    = 0;
        n_nod    = 0;
        n_err    = 0;
        sel_code = '0;
    endtask

    task automatic recarga();
        @(posedge clk);
        #1 bus.RECARGA = 1'b1;
        @(posedge clk);
        #1 bus.RECARGA = 1'b0;
    endtask

    // One withdrawal; ruido re-pulses start/changes MONTO mid-flight,
    // con_recarga asserts RECARGA together with the start
    task automatic tx(input logic [31:0] m, input bit ruido,
                      input bit con_recarga);
        clr();
        @(posedge clk);
        #1;
        bus.MONTO           = m;
        bus.ENTREGAR_DINERO = 1'b1;
        bus.RECARGA         = con_recarga;
        @(posedge clk);
        #1;
        bus.RECARGA = 1'b0;
        if (ruido) begin
            bus.MONTO = 32'd5;
            repeat (3) @(posedge clk);
            #1;
        end
        bus.ENTREGAR_DINERO = 1'b0;
        cyc = 0;
        while (bus.DISPENSANDO && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("tx_bound", 32'(cyc < 2000), 32'd1);
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic chk_inv(input string tag, input int a, input int b,
                           input int c);
        chk({tag, "_inv0"}, 32'(dut.inv_q[0]), a);
        chk({tag, "_inv1"}, 32'(dut.inv_q[1]), b);
        chk({tag, "_inv2"}, 32'(dut.inv_q[2]), c);
    endtask

    initial begin
        bus.ENTREGAR_DINERO = 1'b0;
        bus.MONTO           = '0;
        bus.RECARGA         = 1'b0;
        bus.BILLETE_ACK     = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_req", bus.BILLETE_REQ, 0);
        chk("rst_disp", bus.DISPENSANDO, 0);
        chk("rst_fin", bus.ENTREGA_COMPLETA, 0);
        chk("rst_nod", bus.MONTO_NO_DISPENSABLE, 0);
        chk("rst_err", bus.ERROR_DISPENSADOR, 0);
        chk("rst_ent", bus.MONTO_ENTREGADO, 0);
        chk_inv("rst", 10, 10, 10);

        echo = 1'b1;
        tx(32'd0, 1'b0, 1'b0);
        chk("z_fin", n_fin, 1);
        chk("z_bills", n_bill, 0);
        chk("z_ent", bus.MONTO_ENTREGADO, 0);

        tx(32'd75, 1'b1, 1'b0);
        chk("m75_bills", n_bill, 3);
        chk("m75_sel", sel_code, 32'h24);
        chk("m75_fin", n_fin, 1);
        chk("m75_ent", bus.MONTO_ENTREGADO, 75);
        chk("m75_err", n_err, 0);
        chk_inv("m75", 9, 9, 9);

        tx(32'd77, 1'b0, 1'b0);
        chk("m77_nod", n_nod, 1);
        chk("m77_req", n_req_hi, 0);
        chk("m77_fin", n_fin, 0);
        chk("m77_fast", 32'(cyc <= 10), 1);
        chk_inv("m77", 9, 9, 9);

        recarga();
        chk_inv("rec", 10, 10, 10);

        tx(32'd600, 1'b0, 1'b0);
`ifdef DISPENSADOR_LIMITE_EN
        chk("m600_nod", n_nod, 1);
        chk("m600_req", n_req_hi, 0);
        chk_inv("m600", 10, 10, 10);
        tx(32'd50, 1'b0, 1'b0);
        chk("m50_bills", n_bill, 1);
        chk("m50_sel", sel_code, 32'h0);
        chk("m50_ent", bus.MONTO_ENTREGADO, 50);
        chk_inv("m50", 9, 10, 10);
`else
        chk("m600_bills", n_bill, 15);
        chk("m600_sel", sel_code, 32'h15500000);
        chk("m600_ent", bus.MONTO_ENTREGADO, 600);
        chk("m600_fin", n_fin, 1);
        chk_inv("m600", 0, 5, 10);
        tx(32'd50, 1'b0, 1'b0);
        chk("m50_bills", n_bill, 4);
        chk("m50_sel", sel_code, 32'hA5);
        chk("m50_ent", bus.MONTO_ENTREGADO, 50);
        chk_inv("m50", 0, 3, 8);
`endif

        tx(32'd100, 1'b0, 1'b1);
        chk("m100_bills", n_bill, 2);
        chk("m100_sel", sel_code, 32'h0);
        chk("m100_ent", bus.MONTO_ENTREGADO, 100);
        chk_inv("m100", 8, 10, 10);

        recarga();
        echo = 1'b0;
        tx(32'd20, 1'b0, 1'b0);
        chk("tmo_req_cycles", n_req_hi, 16);
        chk("tmo_err", n_err, 1);
        chk("tmo_fin", n_fin, 0);
        chk("tmo_disp", bus.DISPENSANDO, 0);
        chk_inv("tmo", 10, 10, 10);

        echo = 1'b1;
        clr();
        @(posedge clk);
        #1;
        bus.MONTO           = 32'd75;
        bus.ENTREGAR_DINERO = 1'b1;
        @(posedge clk);
        #1 bus.ENTREGAR_DINERO = 1'b0;
        cyc = 0;
        while (!(n_req_hi > 0 && bus.DISPENSANDO && !bus.BILLETE_REQ)
               && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rmid_reach", 32'(cyc < 200), 1);
        chk("rmid_ent_pre", bus.MONTO_ENTREGADO, 50);
        reset = 1'b1;
        echo  = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rmid_req", bus.BILLETE_REQ, 0);
        chk("rmid_disp", bus.DISPENSANDO, 0);
        chk("rmid_sel", bus.CASETE_SEL, 0);
        chk("rmid_fin", bus.ENTREGA_COMPLETA, 0);
        chk("rmid_nod", bus.MONTO_NO_DISPENSABLE, 0);
        chk("rmid_err", bus.ERROR_DISPENSADOR, 0);
        chk("rmid_ent", bus.MONTO_ENTREGADO, 0);
        chk_inv("rmid", 10, 10, 10);
        recarga();
        chk_inv("rmid_rec", 10, 10, 10);
        chk("rmid_idle", bus.DISPENSANDO, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/secuenciador_dispensador.md
Name: secuenciador_dispensador

Overview:
Controls the cash-dispenser mechanism once the ATM controller authorises a withdrawal via ENTREGAR_DINERO. Latches MONTO and splits it greedily across three denomination cassettes, bounded by per-cassette inventory. Then drives one bill at a time through a four-phase REQ/ACK handshake with a timeout. Keeps per-cassette inventory and reports completion, rejection or mechanism failure.

Parameters:
DEN_0, 50, face value of cassette 0 (largest)
DEN_1, 20, face value of cassette 1
DEN_2, 5, face value of cassette 2 (smallest); DEN_0 > DEN_1 > DEN_2 > 0
INV_INICIAL, 10, bills per cassette after reset/recarga (16-bit counters)
TIMEOUT, 16, max cycles waiting on any ACK edge
MAX_BILLETES, 8, bill limit per transaction (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ENTREGAR_DINERO  in  1  start request, sampled only in IDLE
MONTO  in  32  amount, latched on accepted start
RECARGA  in  1  refill all cassettes to INV_INICIAL, honoured only in IDLE
BILLETE_ACK  in  1  mechanism acknowledge
BILLETE_REQ  out  1  mechanism request, one bill
CASETE_SEL  out  2  cassette for current REQ (0..2)
DISPENSANDO  out  1  high in every state except IDLE
ENTREGA_COMPLETA  out  1  one-cycle pulse, all bills delivered
MONTO_NO_DISPENSABLE  out  1  one-cycle pulse, amount rejected
ERROR_DISPENSADOR  out  1  one-cycle pulse, handshake timeout
MONTO_ENTREGADO  out  32  running sum of face values delivered in current/last transaction

Behaviour:
- Reset: all outputs 0, state IDLE, inventories = INV_INICIAL, bill counts 0.
- States: IDLE, CALCULO, REQ_ALTO, ESPERA_BAJO, FIN.
- IDLE: ENTREGAR_DINERO=1 -> latch MONTO into resto, clear counts and MONTO_ENTREGADO, idx=0, go CALCULO next cycle.
- IDLE with RECARGA=1 and ENTREGAR_DINERO=1 together: refill first, then start; the new transaction sees full inventory.
- CALCULO, one step per cycle: if resto >= DEN_idx and cnt_idx < inv_idx, then resto -= DEN_idx and cnt_idx++. Otherwise idx++.
- When idx passes 2 and resto != 0: pulse MONTO_NO_DISPENSABLE, go IDLE, inventory untouched, no REQ issued.
- When idx passes 2 and resto == 0: go REQ_ALTO, pointing at the lowest cassette with cnt > 0. If all counts are 0 (MONTO=0), go FIN directly.
- REQ_ALTO: BILLETE_REQ=1, CASETE_SEL=current cassette. On ACK=1, drop REQ next cycle, decrement cnt and inv of that cassette, add its DEN to MONTO_ENTREGADO, go ESPERA_BAJO.
- ESPERA_BAJO: wait ACK=0, then go to the next bill (same cassette while cnt>0, else next nonzero cassette) or FIN. Minimum one REQ-low cycle between bills.
- Timeout counter clears on every state entry. If TIMEOUT cycles pass in REQ_ALTO or ESPERA_BAJO without the awaited ACK level: drop REQ, pulse ERROR_DISPENSADOR, go IDLE.
  - Bills already acknowledged stay deducted; the timed-out bill is not deducted.
- FIN: pulse ENTREGA_COMPLETA for one cycle, go IDLE. MONTO_ENTREGADO holds until the next accepted start.
- ENTREGAR_DINERO and RECARGA are ignored outside IDLE. MONTO changes after the latch have no effect.
- Reset mid-operation wins in any state: immediate return to reset values, including full inventory.
- Arithmetic: resto and MONTO_ENTREGADO are 32-bit unsigned. Subtraction occurs only when resto >= DEN, so there is no underflow.

Optional Feature:
DISPENSADOR_LIMITE_EN: when defined, after CALCULO succeeds, if the summed bill count > MAX_BILLETES: pulse MONTO_NO_DISPENSABLE, go IDLE, no REQ issued. When undefined, there is no limit and the parameter is unused.

Test Plan:
- MONTO=75, ACK echoes REQ after 2 cycles -> three handshakes with CASETE_SEL 0,1,2; ENTREGA_COMPLETA once; MONTO_ENTREGADO=75; inventories 9,9,9.
- MONTO=77 -> MONTO_NO_DISPENSABLE pulse, BILLETE_REQ never high, inventories unchanged, DISPENSADOR back to IDLE within ~10 cycles.
- MONTO=600 then MONTO=50 -> first: 10x cassette0, 5x cassette1, inv 0,5,10. Second: 2x cassette1, 2x cassette2, inv 0,3,8, MONTO_ENTREGADO=50.
- MONTO=20, ACK held 0 -> REQ high exactly 16 cycles, then ERROR_DISPENSADOR pulse, IDLE, inv1 still 10.
- Reset asserted in ESPERA_BAJO of a 75 withdrawal -> next cycle all outputs 0, inventories 10. Subsequent RECARGA in IDLE keeps them at 10.
- DISPENSADOR_LIMITE_EN defined, MONTO=600 (15 bills) -> MONTO_NO_DISPENSABLE pulse, no REQ; MONTO=75 still completes.
